caravel_core_cfg: RTL and testbench
===================================

Name: caravel_core_cfg

Overview:
- Per-pad GPIO configuration core for the 38 user-project IO pads (mprj_io[37:0]).
- Holds one 13-bit configuration word per pad. Each word resets to a per-pad compile-time default.
- The words are rewritten through a simple register port and decoded into the pad control buses.
- Also exports the default vector and the mask revision ID. The block sits between management/user logic and the pad ring.

Parameters:
- NUM_IO, 38, number of pads.
- MASK_REV, 32'h0000_0000, project chip ID driven on mask_rev.
- GPIO_DEFAULTS, {38{13'h0403}}, concatenated defaults; pad i uses bits [13*i +: 13].

Ports:
- clock_core  in  1  core clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  write strobe.
- cfg_addr  in  6  pad index for write and read.
- cfg_wdata  in  13  write data.
- cfg_rdata  out  13  readback of the active word at cfg_addr; combinational.
- cfg_load  in  1  apply pending (shadow) words to active; used only with GPIO_SHADOW_EN.
- mgmt_io_out  in  38  management-side output data.
- user_io_out  in  38  user output data.
- user_io_oeb  in  38  user output enable, active low.
- user_io_in  out  38  pad input to user; equals mprj_io_in.
- mprj_io_in  in  38  pad input data.
- mprj_io_out, mprj_io_oeb  out  38 each  pad output data and enable.
- mprj_io_holdover, mprj_io_inp_dis, mprj_io_ib_mode_sel, mprj_io_analog_en, mprj_io_analog_sel, mprj_io_analog_pol, mprj_io_slow_sel, mprj_io_vtrip_sel  out  38 each  pad controls.
- mprj_io_dm  out  114  drive mode, 3 bits per pad, pad i at [3*i +: 3].
- mprj_io_one  out  38  constant all-ones.
- gpio_defaults_out  out  494  equals GPIO_DEFAULTS.
- mask_rev  out  32  equals MASK_REV.

Behaviour:
- Configuration word bit map:
  - [0] mgmt_ena
  - [1] outenb
  - [2] holdover
  - [3] inp_dis
  - [4] ib_mode_sel
  - [5] analog_en
  - [6] analog_sel
  - [7] analog_pol
  - [8] slow_sel
  - [9] vtrip_sel
  - [12:10] dm
- Reset: every active word (and shadow word, if present) loads GPIO_DEFAULTS slice i on the first clock edge with reset=1.
- Reset has priority over cfg_we and cfg_load.
- Outputs after reset follow the defaults. With 13'h0403 on every pad:
  - mgmt_ena=1, outenb=1, dm=3'b001.
  - mprj_io_oeb = 38'h3F_FFFF_FFFF, mprj_io_out = mgmt_io_out.
  - All other control buses 0.
- Write: cfg_we=1 with cfg_addr<NUM_IO updates the word one cycle later (active word, or shadow word with GPIO_SHADOW_EN).
- cfg_addr>=NUM_IO: the write is ignored and cfg_rdata=13'h0.
- Pad i decode is purely combinational from active word i:
  - mprj_io_out[i] = mgmt_ena ? mgmt_io_out[i] : user_io_out[i].
  - mprj_io_oeb[i] = mgmt_ena ? outenb : user_io_oeb[i].
  - The other control buses copy their field directly.
- gpio_defaults_out, mask_rev and mprj_io_one are constants and unaffected by reset or writes.
- user_io_in = mprj_io_in, combinational and unregistered.

Optional Feature:
- Macro GPIO_SHADOW_EN.
- Defined:
  - Writes target a 38x13 shadow array.
  - cfg_load=1 copies the whole shadow array to the active array on that edge. A write in the same cycle lands in shadow only; the copy uses pre-write shadow contents.
  - cfg_rdata still returns the active word.
- Undefined:
  - No shadow storage; writes go directly to the active word.
  - cfg_load is ignored.

Test Plan:
- Reset with default parameters -> gpio_defaults_out slice i = 13'h0403 for all i; mprj_io_oeb=all ones; mprj_io_dm[2:0]=3'b001; mask_rev=MASK_REV.
- Write addr 5 data 13'h1808 (dm=3'b110, inp_dis=1, mgmt_ena=0); user_io_out[5]=1, user_io_oeb[5]=0 -> next cycle mprj_io_out[5]=1, mprj_io_oeb[5]=0, mprj_io_dm[17:15]=3'b110, mprj_io_inp_dis[5]=1; cfg_rdata at addr 5 = 13'h1808.
- Write addr 38 data 13'h1FFF -> no pad changes; cfg_rdata at addr 38 = 0.
- Assert reset after writes -> all words return to defaults on the next edge; reset held with cfg_we=1 -> no write takes effect.
- GPIO_SHADOW_EN: write addr 0 = 13'h0000 -> cfg_rdata stays 13'h0403; then cfg_load -> 13'h0000 next cycle. Write plus load in the same cycle -> new value is not applied until a second load.
- Drive mprj_io_in=38'h2A_AAAA_AAAA -> user_io_in identical in the same cycle.

Source files
------------

// File: rtl/caravel_core_cfg.sv
// caravel_core_cfg: per-pad configuration store and pad-control decode for the
// user-project IO ring. Each pad owns one 13-bit word:
//   [0] mgmt_ena  [1] outenb  [2] holdover  [3] inp_dis  [4] ib_mode_sel
//   [5] analog_en [6] analog_sel [7] analog_pol [8] slow_sel [9] vtrip_sel
//   [12:10] dm
// Optional build macro GPIO_SHADOW_EN: writes land in a shadow array that is
// copied to the active array as a whole on cfg_load.
module caravel_core_cfg #(
  parameter int                   NUM_IO        = 38,
  parameter logic [31:0]          MASK_REV      = 32'h0000_0000,
  parameter logic [13*NUM_IO-1:0] GPIO_DEFAULTS = {NUM_IO{13'h0403}}
) (
  input  logic                   clock_core,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [5:0]             cfg_addr,
  input  logic [12:0]            cfg_wdata,
  output logic [12:0]            cfg_rdata,
  input  logic                   cfg_load,
  input  logic [NUM_IO-1:0]      mgmt_io_out,
  input  logic [NUM_IO-1:0]      user_io_out,
  input  logic [NUM_IO-1:0]      user_io_oeb,
  output logic [NUM_IO-1:0]      user_io_in,
  input  logic [NUM_IO-1:0]      mprj_io_in,
  output logic [NUM_IO-1:0]      mprj_io_out,
  output logic [NUM_IO-1:0]      mprj_io_oeb,
  output logic [NUM_IO-1:0]      mprj_io_holdover,
  output logic [NUM_IO-1:0]      mprj_io_inp_dis,
  output logic [NUM_IO-1:0]      mprj_io_ib_mode_sel,
  output logic [NUM_IO-1:0]      mprj_io_analog_en,
  output logic [NUM_IO-1:0]      mprj_io_analog_sel,
  output logic [NUM_IO-1:0]      mprj_io_analog_pol,
  output logic [NUM_IO-1:0]      mprj_io_slow_sel,
  output logic [NUM_IO-1:0]      mprj_io_vtrip_sel,
  output logic [3*NUM_IO-1:0]    mprj_io_dm,
  output logic [NUM_IO-1:0]      mprj_io_one,
  output logic [13*NUM_IO-1:0]   gpio_defaults_out,
  output logic [31:0]            mask_rev
);

  logic [12:0] active [NUM_IO];
  logic        addr_ok;

  // Out-of-range pad indices neither write nor read anything.
  assign addr_ok = (cfg_addr < 6'(NUM_IO));

`ifdef GPIO_SHADOW_EN
  logic [12:0] shadow [NUM_IO];

  // Shadow array: reset to defaults, then takes every in-range write.
  always_ff @(posedge clock_core) begin
    if (reset) begin
      for (int i = 0; i < NUM_IO; i++) shadow[i] <= GPIO_DEFAULTS[13*i +: 13];
    end else if (cfg_we && addr_ok) begin
      shadow[cfg_addr] <= cfg_wdata;
    end
  end

  // Active array: bulk copy of the shadow on load; a same-cycle write is not
  // part of the copy because the old shadow value is sampled on this edge.
  always_ff @(posedge clock_core) begin
    if (reset) begin
      for (int i = 0; i < NUM_IO; i++) active[i] <= GPIO_DEFAULTS[13*i +: 13];
    end else if (cfg_load) begin
      for (int i = 0; i < NUM_IO; i++) active[i] <= shadow[i];
    end
  end
`else
  logic unused_cfg_load;
  assign unused_cfg_load = cfg_load;

  // Active array: reset to defaults, otherwise written directly.
  always_ff @(posedge clock_core) begin
    if (reset) begin
      for (int i = 0; i < NUM_IO; i++) active[i] <= GPIO_DEFAULTS[13*i +: 13];
    end else if (cfg_we && addr_ok) begin
      active[cfg_addr] <= cfg_wdata;
    end
  end
`endif

  // Readback always reflects the word currently driving the pad.
  always_comb begin
    cfg_rdata = 13'h0000;
    if (addr_ok) cfg_rdata = active[cfg_addr];
  end

  for (genvar i = 0; i < NUM_IO; i++) begin : g_pad
    assign mprj_io_out[i]         = active[i][0] ? mgmt_io_out[i] : user_io_out[i];
    assign mprj_io_oeb[i]         = active[i][0] ? active[i][1]   : user_io_oeb[i];
    assign mprj_io_holdover[i]    = active[i][2];
    assign mprj_io_inp_dis[i]     = active[i][3];
    assign mprj_io_ib_mode_sel[i] = active[i][4];
    assign mprj_io_analog_en[i]   = active[i][5];
    assign mprj_io_analog_sel[i]  = active[i][6];
    assign mprj_io_analog_pol[i]  = active[i][7];
    assign mprj_io_slow_sel[i]    = active[i][8];
    assign mprj_io_vtrip_sel[i]   = active[i][9];
    assign mprj_io_dm[3*i +: 3]   = active[i][12:10];
  end

  assign user_io_in        = mprj_io_in;
  assign mprj_io_one       = '1;
  assign gpio_defaults_out = GPIO_DEFAULTS;
  assign mask_rev          = MASK_REV;

endmodule

// File: tb/tb_caravel_core_cfg.sv
// tb_caravel_core_cfg: directed bench with a scoreboard queue. Expected pad
// buses are computed from a bench-side model of the configuration words and
// pushed before each clock edge, then popped and compared after it.
module tb_caravel_core_cfg;

  localparam int          N   = 38;
  localparam logic [12:0] DEF = 13'h0403;

  logic            clk = 1'b0;
  logic            reset;
  logic            cfg_we;
  logic [5:0]      cfg_addr;
  logic [12:0]     cfg_wdata;
  logic [12:0]     cfg_rdata;
  logic            cfg_load;
  logic [N-1:0]    mgmt_io_out, user_io_out, user_io_oeb, user_io_in, mprj_io_in;
  logic [N-1:0]    mprj_io_out, mprj_io_oeb, mprj_io_holdover, mprj_io_inp_dis;
  logic [N-1:0]    mprj_io_ib_mode_sel, mprj_io_analog_en, mprj_io_analog_sel;
  logic [N-1:0]    mprj_io_analog_pol, mprj_io_slow_sel, mprj_io_vtrip_sel;
  logic [3*N-1:0]  mprj_io_dm;
  logic [N-1:0]    mprj_io_one;
  logic [13*N-1:0] gpio_defaults_out;
  logic [31:0]     mask_rev;

  caravel_core_cfg dut (
    .clock_core(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_load(cfg_load),
    .mgmt_io_out(mgmt_io_out), .user_io_out(user_io_out), .user_io_oeb(user_io_oeb),
    .user_io_in(user_io_in), .mprj_io_in(mprj_io_in), .mprj_io_out(mprj_io_out),
    .mprj_io_oeb(mprj_io_oeb), .mprj_io_holdover(mprj_io_holdover),
    .mprj_io_inp_dis(mprj_io_inp_dis), .mprj_io_ib_mode_sel(mprj_io_ib_mode_sel),
    .mprj_io_analog_en(mprj_io_analog_en), .mprj_io_analog_sel(mprj_io_analog_sel),
    .mprj_io_analog_pol(mprj_io_analog_pol), .mprj_io_slow_sel(mprj_io_slow_sel),
    .mprj_io_vtrip_sel(mprj_io_vtrip_sel), .mprj_io_dm(mprj_io_dm),
    .mprj_io_one(mprj_io_one), .gpio_defaults_out(gpio_defaults_out),
    .mask_rev(mask_rev)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [127:0] exp;
  } sb_t;

  sb_t         sbq[$];
  int          checks   = 0;
  int          failures = 0;
  logic [12:0] act [N];
  logic [12:0] sh  [N];

  task automatic push(input string t, input logic [127:0] e);
    sbq.push_back('{t, e});
  endtask

  task automatic pop_check(input string t, input logic [127:0] obs);
    sb_t s;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty, observed=%0h", t, obs);
    end else begin
      s = sbq.pop_front();
      assert (s.tag == t && obs === s.exp) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h (queued tag %s)", t, obs, s.exp, s.tag);
      end
    end
  endtask

  function automatic logic [N-1:0] fld(input int b);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = act[i][b];
    return v;
  endfunction

  function automatic logic [3*N-1:0] dm_vec();
    logic [3*N-1:0] v;
    for (int i = 0; i < N; i++) v[3*i +: 3] = act[i][12:10];
    return v;
  endfunction

  function automatic logic [N-1:0] out_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = act[i][0] ? mgmt_io_out[i] : user_io_out[i];
    return v;
  endfunction

  function automatic logic [N-1:0] oeb_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = act[i][0] ? act[i][1] : user_io_oeb[i];
    return v;
  endfunction

  task automatic push_all();
    push("out", 128'(out_vec()));
    push("oeb", 128'(oeb_vec()));
    push("holdover", 128'(fld(2)));
    push("inp_dis", 128'(fld(3)));
    push("ib_mode_sel", 128'(fld(4)));
    push("analog_en", 128'(fld(5)));
    push("analog_sel", 128'(fld(6)));
    push("analog_pol", 128'(fld(7)));
    push("slow_sel", 128'(fld(8)));
    push("vtrip_sel", 128'(fld(9)));
    push("dm", 128'(dm_vec()));
    push("rdata", 128'((cfg_addr < 6'(N)) ? act[cfg_addr] : 13'h0000));
  endtask

  task automatic check_all();
    pop_check("out", 128'(mprj_io_out));
    pop_check("oeb", 128'(mprj_io_oeb));
    pop_check("holdover", 128'(mprj_io_holdover));
    pop_check("inp_dis", 128'(mprj_io_inp_dis));
    pop_check("ib_mode_sel", 128'(mprj_io_ib_mode_sel));
    pop_check("analog_en", 128'(mprj_io_analog_en));
    pop_check("analog_sel", 128'(mprj_io_analog_sel));
    pop_check("analog_pol", 128'(mprj_io_analog_pol));
    pop_check("slow_sel", 128'(mprj_io_slow_sel));
    pop_check("vtrip_sel", 128'(mprj_io_vtrip_sel));
    pop_check("dm", 128'(mprj_io_dm));
    pop_check("rdata", 128'(cfg_rdata));
  endtask

  // Drives one clock cycle, advances the model, and checks all pad buses after the edge.
  task automatic cycle(input logic rst, input logic we, input logic [5:0] a,
                       input logic [12:0] d, input logic ld);
    reset = rst; cfg_we = we; cfg_addr = a; cfg_wdata = d; cfg_load = ld;
    if (rst) begin
      for (int i = 0; i < N; i++) begin act[i] = DEF; sh[i] = DEF; end
    end else begin
`ifdef GPIO_SHADOW_EN
      if (ld) for (int i = 0; i < N; i++) act[i] = sh[i];
      if (we && a < 6'(N)) sh[a] = d;
`else
      if (we && a < 6'(N)) act[a] = d;
`endif
    end
    push_all();
    @(posedge clk);
    #1;
    reset = 1'b0; cfg_we = 1'b0; cfg_load = 1'b0;
    check_all();
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_load = 1'b0;
    mgmt_io_out = 38'h15_5555_5555; user_io_out = 38'h0A_AAAA_AAAA;
    user_io_oeb = '1; mprj_io_in = '0;
    for (int i = 0; i < N; i++) begin act[i] = 'x; sh[i] = 'x; end

    // Reset with a write held: reset wins and defaults appear.
    cycle(1'b1, 1'b1, 6'd5, 13'h1FFF, 1'b0);
    cycle(1'b0, 1'b0, 6'd0, 13'h0000, 1'b0);
    for (int i = 0; i < N; i++) begin
      push($sformatf("defaults[%0d]", i), 128'(DEF));
      pop_check($sformatf("defaults[%0d]", i), 128'(gpio_defaults_out[13*i +: 13]));
    end
    push("oeb_reset", 128'(38'h3F_FFFF_FFFF)); pop_check("oeb_reset", 128'(mprj_io_oeb));
    push("dm0_reset", 128'(3'b001));           pop_check("dm0_reset", 128'(mprj_io_dm[2:0]));
    push("out_reset", 128'(mgmt_io_out));      pop_check("out_reset", 128'(mprj_io_out));
    push("mask_rev", 128'(32'h0000_0000));     pop_check("mask_rev", 128'(mask_rev));
    push("one", 128'({N{1'b1}}));              pop_check("one", 128'(mprj_io_one));

    // Pad 5 into user mode with dm=110 and input disabled.
    mgmt_io_out = '0; user_io_out = 38'(1) << 5; user_io_oeb = ~(38'(1) << 5);
    cycle(1'b0, 1'b1, 6'd5, 13'h1808, 1'b0);
`ifdef GPIO_SHADOW_EN
    cycle(1'b0, 1'b0, 6'd5, 13'h0000, 1'b1);
`endif
    push("out5", 128'(1'b1));       pop_check("out5", 128'(mprj_io_out[5]));
    push("oeb5", 128'(1'b0));       pop_check("oeb5", 128'(mprj_io_oeb[5]));
    push("dm5", 128'(3'b110));      pop_check("dm5", 128'(mprj_io_dm[17:15]));
    push("inp_dis5", 128'(1'b1));   pop_check("inp_dis5", 128'(mprj_io_inp_dis[5]));
    push("rdata5", 128'(13'h1808)); pop_check("rdata5", 128'(cfg_rdata));

    // Last pad: management mode driving, many single-bit controls set.
    mgmt_io_out = 38'h3A_5C3C_A5F0; user_io_out = 38'h05_A3C3_5A0F; user_io_oeb = 38'h15_0F0F_3C3C;
    cycle(1'b0, 1'b1, 6'd37, 13'h03E5, 1'b0);
    cycle(1'b0, 1'b1, 6'd0, 13'h0412, 1'b1);
    cycle(1'b0, 1'b1, 6'd1, 13'h1C00, 1'b1);
    cycle(1'b0, 1'b0, 6'd1, 13'h0000, 1'b1);

    // Out-of-range addresses: no write, zero readback.
    cycle(1'b0, 1'b1, 6'd38, 13'h1FFF, 1'b0);
    cycle(1'b0, 1'b1, 6'd63, 13'h1FFF, 1'b1);
    cycle(1'b0, 1'b0, 6'd38, 13'h0000, 1'b0);

    // Combinational data path: user/mgmt data changes without a clock.
    user_io_out = ~user_io_out; mgmt_io_out = ~mgmt_io_out;
    push("out_comb", 128'(out_vec()));
    #1;
    pop_check("out_comb", 128'(mprj_io_out));

    // Reset after writes, with a write held during reset.
    cycle(1'b1, 1'b1, 6'd5, 13'h0000, 1'b1);
    cycle(1'b0, 1'b0, 6'd5, 13'h0000, 1'b0);

    // Write to pad 0, then load; then write+load together and a second load.
    cycle(1'b0, 1'b1, 6'd0, 13'h0000, 1'b0);
    cycle(1'b0, 1'b0, 6'd0, 13'h0000, 1'b1);
    cycle(1'b0, 1'b1, 6'd0, 13'h1555, 1'b1);
    cycle(1'b0, 1'b0, 6'd0, 13'h0000, 1'b0);
    cycle(1'b0, 1'b0, 6'd0, 13'h0000, 1'b1);

    // Pad input passthrough, same cycle.
    mprj_io_in = 38'h2A_AAAA_AAAA;
    push("user_io_in", 128'(38'h2A_AAAA_AAAA));
    #1;
    pop_check("user_io_in", 128'(user_io_in));
    mprj_io_in = 38'h15_5555_5555;
    push("user_io_in_inv", 128'(38'h15_5555_5555));
    #1;
    pop_check("user_io_in_inv", 128'(user_io_in));

    if (sbq.size() != 0) begin
      checks++; failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
